// File: rtl/trax_move_parser.sv
// Trax move parser: turns a stream of ASCII bytes from the UART receiver into
// packed move words, colour assignments, or parse-error pulses, one per line.
module trax_move_parser #(
    parameter int COORD_W   = 10,
    parameter int MAX_COORD = 1023
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic [2*COORD_W+1:0]   move_out,
    output logic                   end_receive,
    output logic                   color,
    output logic                   color_valid,
    output logic                   parse_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_COL, S_ROW, S_EOL, S_COLOR, S_ERR
    } state_t;

    state_t               state;
    logic [COORD_W-1:0]   col_acc;
    logic [COORD_W-1:0]   row_acc;
    logic                 col_at;
    logic                 digit_seen;
    logic [1:0]           tile;
    logic                 pend_color;
    logic                 color_seen;

    logic                 is_lf, is_cr, is_upper, is_digit, is_tile;
    logic [1:0]           tile_code;
    logic [7:0]           letter, digit;
    logic [14:0]          col_next;
    logic [13:0]          row_next;
    logic                 col_ovf, row_ovf;

    // Byte classification and the next accumulator values (col*26+l, row*10+d)
    always_comb begin
        is_lf     = (rx_byte == 8'h0A);
        is_cr     = (rx_byte == 8'h0D);
        is_upper  = (rx_byte >= 8'h41) && (rx_byte <= 8'h5A);
        is_digit  = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
        is_tile   = 1'b1;
        tile_code = 2'd0;
        case (rx_byte)
            8'h2B:   tile_code = 2'd0;   // '+'
            8'h2F:   tile_code = 2'd1;   // '/'
            8'h5C:   tile_code = 2'd2;   // '\'
            default: is_tile   = 1'b0;
        endcase
        letter   = rx_byte - 8'h40;
        digit    = rx_byte - 8'h30;
        col_next = 15'(col_acc) * 15'd26 + 15'(letter);
        row_next = 14'(row_acc) * 14'd10 + 14'(digit);
        col_ovf  = col_next > 15'(MAX_COORD);
        row_ovf  = row_next > 14'(MAX_COORD);
    end

    // Line parser FSM with registered outputs; every LF returns to S_IDLE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            col_acc     <= '0;
            row_acc     <= '0;
            col_at      <= 1'b0;
            digit_seen  <= 1'b0;
            tile        <= 2'd0;
            pend_color  <= 1'b0;
            color_seen  <= 1'b0;
            move_out    <= '0;
            end_receive <= 1'b0;
            color       <= 1'b0;
            color_valid <= 1'b0;
            parse_error <= 1'b0;
        end else begin
            end_receive <= 1'b0;
            color_valid <= 1'b0;
            parse_error <= 1'b0;
            if (rx_valid && !is_cr) begin
                if (is_lf) begin
                    // Line terminator: report what the line was, then clear
                    state      <= S_IDLE;
                    col_acc    <= '0;
                    row_acc    <= '0;
                    col_at     <= 1'b0;
                    digit_seen <= 1'b0;
                    tile       <= 2'd0;
                    pend_color <= 1'b0;
                    color_seen <= 1'b0;
                    case (state)
                        S_IDLE: ;  // empty line
                        S_EOL: begin
                            move_out    <= {tile, row_acc, col_acc};
                            end_receive <= 1'b1;
                        end
                        S_COLOR: begin
                            if (color_seen) begin
                                color       <= pend_color;
                                color_valid <= 1'b1;
                            end else begin
                                parse_error <= 1'b1;
                            end
                        end
                        // LF inside a coordinate or in the error state ends a bad line
                        default: parse_error <= 1'b1;
                    endcase
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (rx_byte == 8'h2D) begin
                                state <= S_COLOR;
                            end else if (rx_byte == 8'h40) begin
                                col_acc <= '0;
                                col_at  <= 1'b1;
                                state   <= S_ROW;
                            end else if (is_upper) begin
                                // accumulator is zero here, so col_next is just the letter
                                col_acc <= col_next[COORD_W-1:0];
                                state   <= S_COL;
                            end else begin
                                state <= S_ERR;
                            end
                        end
                        S_COL: begin
                            if (is_upper) begin
                                if (col_ovf) state <= S_ERR;
                                else         col_acc <= col_next[COORD_W-1:0];
                            end else if (is_digit) begin
                                row_acc    <= row_next[COORD_W-1:0];
                                digit_seen <= 1'b1;
                                state      <= S_ROW;
                            end else begin
                                state <= S_ERR;
                            end
                        end
                        S_ROW: begin
                            if (is_digit) begin
                                // a seen digit with row still zero means a leading '0'
                                if ((digit_seen && row_acc == '0) || row_ovf) begin
                                    state <= S_ERR;
                                end else begin
                                    row_acc    <= row_next[COORD_W-1:0];
                                    digit_seen <= 1'b1;
                                end
                            end else if (is_tile && digit_seen) begin
                                tile  <= tile_code;
                                state <= S_EOL;
                            end else begin
                                state <= S_ERR;
                            end
                        end
                        S_COLOR: begin
                            if ((rx_byte == 8'h57 || rx_byte == 8'h42) && !color_seen) begin
                                pend_color <= (rx_byte == 8'h42);
                                color_seen <= 1'b1;
                            end else begin
                                state <= S_ERR;
                            end
                        end
                        S_EOL:   state <= S_ERR;
                        default: state <= S_ERR;  // S_ERR swallows bytes until LF
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_trax_move_parser.sv
// Directed bench for trax_move_parser: each line pushes its expected event to a
// scoreboard queue; a negedge monitor pops and checks every output pulse.
module tb_trax_move_parser;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic [21:0] move_out;
    logic        end_receive, color, color_valid, parse_error;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] K_MOVE = 3'b100;
    localparam logic [2:0] K_COL  = 3'b010;
    localparam logic [2:0] K_ERR  = 3'b001;

    typedef struct packed {
        logic [2:0]  kind;
        logic [21:0] mv;
        logic        col;
    } exp_t;

    exp_t        q[$];
    logic [21:0] exp_move = '0;
    logic        exp_color = 1'b0;

    trax_move_parser dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .move_out    (move_out),
        .end_receive (end_receive),
        .color       (color),
        .color_valid (color_valid),
        .parse_error (parse_error)
    );

    always #5 clock = ~clock;

    // Scoreboard monitor: every pulse cycle must match the head of the queue
    always @(negedge clock) begin
        exp_t e;
        logic [2:0] k;
        k = {end_receive, color_valid, parse_error};
        if (reset_n && k != 3'b000) begin
            total++;
            assert (q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_pulse kinds=%b expected none", k);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                assert (k === e.kind) else begin
                    bad++;
                    $error("FAIL pulse_kind got=%b want=%b", k, e.kind);
                end
                total++;
                assert (move_out === e.mv) else begin
                    bad++;
                    $error("FAIL move_out got=%06h want=%06h", move_out, e.mv);
                end
                total++;
                assert (color === e.col) else begin
                    bad++;
                    $error("FAIL color got=%b want=%b", color, e.col);
                end
            end
        end
    end

    task automatic push(input logic [2:0] kind);
        exp_t e;
        e.kind = kind;
        e.mv   = exp_move;
        e.col  = exp_color;
        q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    task automatic send_str(input string s, input bit sparse);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (sparse) begin
                int n;
                n = $urandom_range(0, 3);
                repeat (n) begin
                    rx_byte = 8'($urandom);
                    @(posedge clock);
                    #1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_drained(input string tag);
        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL %s pending=%0d want=0", tag, q.size());
        end
    endtask

    task automatic check_zero(input string tag);
        total++;
        assert ({move_out, end_receive, color, color_valid, parse_error} === 26'd0) else begin
            bad++;
            $error("FAIL %s outputs=%07h want=0", tag,
                   {move_out, end_receive, color, color_valid, parse_error});
        end
    endtask

    initial begin
        // Reset state
        #2;
        check_zero("reset_values");
        idle(2);
        reset_n = 1'b1;
        idle(1);

        // Plain move
        exp_move = 22'h000401; push(K_MOVE);
        send_str("A1+\n", 0);
        idle(2);
        check_drained("move_a1");

        // Back-to-back lines with no dead cycle
        exp_move = 22'h100000; push(K_MOVE);
        exp_move = 22'h20301C; push(K_MOVE);
        send_str("@0/\nAB12\\\n", 0);
        idle(2);
        check_drained("back_to_back");

        // Colour lines, the second with a CR
        exp_color = 1'b1; push(K_COL);
        send_str("-B\n", 0);
        exp_color = 1'b0; push(K_COL);
        send_str("-W\r\n", 0);
        idle(2);
        check_drained("colour");

        // Malformed lines, each a single error with move_out unchanged
        push(K_ERR); send_str("A1x\n", 0);    idle(1);
        push(K_ERR); send_str("A01+\n", 0);   idle(1);
        push(K_ERR); send_str("+\n", 0);      idle(1);
        push(K_ERR); send_str("AMN1+\n", 0);  idle(1);
        push(K_ERR); send_str("A1024/\n", 0); idle(2);
        check_drained("errors");

        // Reset in the middle of a line
        send_str("C3", 0);
        reset_n = 1'b0;
        #2;
        check_zero("midline_reset");
        idle(2);
        check_zero("reset_held");
        reset_n = 1'b1;
        exp_move = '0; exp_color = 1'b0;
        idle(1);
        exp_move = 22'h200802; push(K_MOVE);
        send_str("B2\\\n", 0);
        idle(2);
        check_drained("after_reset");

        // Sparse valids with garbage on idle cycles
        exp_move = 22'h00241A; push(K_MOVE);
        send_str("Z9+\n", 1);
        idle(3);
        check_drained("sparse");

        // move_out holds between moves
        total++;
        assert (move_out === 22'h00241A) else begin
            bad++;
            $error("FAIL move_hold got=%06h want=00241a", move_out);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
